// File: rtl/sha3_squeeze.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sha3_squeeze
//
// Squeeze-phase engine for the SHA-3 / SHAKE sponge. A permuted 1600-bit
// Keccak state is captured on start and its rate lanes are streamed out as
// 64-bit digest words over a valid/ready interface. When the rate is used up
// before the digest is complete, the state is handed to the external
// Keccak-f[1600] round engine and squeezing resumes from the returned state.
//
// Parameters
//   RATE_LANES  rate in 64-bit lanes, 1..25 (17 = SHA3-256, 21 = SHAKE128)
//   OUT_WORDS   digest words emitted per start, >= 1
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start          one-cycle request to squeeze state_in (ignored while busy)
//   state_in       permuted state, lane (x,y) at [64*(x+5*y) +: 64]
//   busy           high from the cycle after an accepted start until idle
//   dout           current digest word (lane value, byte order unchanged)
//   dout_valid     dout holds a valid word
//   dout_ready     consumer accepts dout when high together with dout_valid
//   dout_last      marks the final digest word (meaningful with dout_valid)
//   perm_req       level request to the round engine to permute perm_state_out
//   perm_state_out internal state register, same lane mapping as state_in
//   perm_ack       round engine done; perm_state_in valid this cycle
//   perm_state_in  permuted state returned by the round engine
//
// Every output comes straight from a flop, so there is no combinational path
// from any input to any output.
// -----------------------------------------------------------------------------
module sha3_squeeze #(
   parameter int RATE_LANES = 17,
   parameter int OUT_WORDS  = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [1599:0] state_in,
   output logic          busy,
   output logic [63:0]   dout,
   output logic          dout_valid,
   input  logic          dout_ready,
   output logic          dout_last,
   output logic          perm_req,
   output logic [1599:0] perm_state_out,
   input  logic          perm_ack,
   input  logic [1599:0] perm_state_in
);

   localparam int cnt_w = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

   localparam logic [4:0]       last_lane = 5'(RATE_LANES - 1);
   localparam logic [cnt_w-1:0] last_word = cnt_w'(OUT_WORDS - 1);

   typedef enum logic [1:0] {
      s_idle = 2'd0,
      s_out  = 2'd1,
      s_perm = 2'd2
   } state_e;

   // Linear lane i = x + 5*y of a state vector.
   function automatic logic [63:0] lane_of(input logic [1599:0] s,
                                           input logic [4:0]    idx);
      return s[64*idx +: 64];
   endfunction

   // ---------------------------------------------------------------------------
   // Registers and their next values
   // ---------------------------------------------------------------------------
   state_e           state_q, state_d;
   logic [1599:0]    st_q, st_d;
   logic [4:0]       lane_q, lane_d;
   logic [cnt_w-1:0] cnt_q, cnt_d;
   logic [63:0]      dout_q, dout_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;
   logic             busy_q, busy_d;
   logic             req_q, req_d;

   logic [4:0]       lane_inc;
   logic [cnt_w-1:0] cnt_inc;

   assign lane_inc = lane_q + 5'd1;
   assign cnt_inc  = cnt_q + 1'b1;

   // ---------------------------------------------------------------------------
   // Next-state and next-output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every register's next value defaults to its current value before
      // the case statement, so no path through it can leave a signal unassigned
      // and infer a latch.
      state_d = state_q;
      st_d    = st_q;
      lane_d  = lane_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      valid_d = valid_q;
      last_d  = last_q;
      busy_d  = busy_q;
      req_d   = req_q;

      unique case (state_q)
         s_idle: begin
            if (start) begin
               state_d = s_out;
               st_d    = state_in;
               lane_d  = '0;
               cnt_d   = '0;
               // The first word is loaded straight from state_in so that it is
               // presented in the very next cycle.
               dout_d  = state_in[63:0];
               valid_d = 1'b1;
               last_d  = (last_word == '0);
               busy_d  = 1'b1;
            end
         end

         s_out: begin
            // dout_valid is always high here, so dout_ready alone marks a
            // handshake; without one, every output simply holds.
            if (dout_ready) begin
               if (last_q) begin
                  state_d = s_idle;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  busy_d  = 1'b0;
               end else if (lane_q == last_lane) begin
                  // Rate exhausted: hand the whole state to the round engine.
                  state_d = s_perm;
                  lane_d  = '0;
                  cnt_d   = cnt_inc;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  req_d   = 1'b1;
               end else begin
                  lane_d  = lane_inc;
                  cnt_d   = cnt_inc;
                  dout_d  = lane_of(st_q, lane_inc);
                  last_d  = (cnt_inc == last_word);
               end
            end
         end

         s_perm: begin
            if (perm_ack) begin
               state_d = s_out;
               st_d    = perm_state_in;
               dout_d  = perm_state_in[63:0];
               valid_d = 1'b1;
               last_d  = (cnt_q == last_word);
               req_d   = 1'b0;
            end
         end

         default: begin
            state_d = s_idle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: the wide state register is reset along with everything else so that
   // perm_state_out reads zero after reset instead of a stale state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= s_idle;
         st_q    <= '0;
         lane_q  <= '0;
         cnt_q   <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         req_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every flop samples the
         // values computed from the previous cycle regardless of statement order.
         state_q <= state_d;
         st_q    <= st_d;
         lane_q  <= lane_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         req_q   <= req_d;
      end
   end

   assign busy           = busy_q;
   assign dout           = dout_q;
   assign dout_valid     = valid_q;
   assign dout_last      = last_q;
   assign perm_req       = req_q;
   assign perm_state_out = st_q;

endmodule

// File: tb/tb_sha3_squeeze.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sha3_squeeze
//
// Three instances cover the parameter sets of interest: (17,4), (17,20) and
// (1,3). They share stimulus; start and perm_ack are gated to the selected
// instance and its outputs are viewed through a mux. The expected digest is
// derived from the sponge rule: word k comes from lane (k mod R) of the k/R-th
// state in the chain state_in, perm result 1, perm result 2, ...
// -----------------------------------------------------------------------------
module tb_sha3_squeeze;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [1599:0] state_in = '0;
   logic          dout_ready = 1'b0;
   logic          perm_ack = 1'b0;
   logic [1599:0] perm_state_in = '0;
   logic [1:0]    sel = 2'd0;

   always #5 clk = ~clk;

   logic          start_g [3];
   logic          ack_g   [3];
   logic          busy_o  [3];
   logic [63:0]   dout_o  [3];
   logic          valid_o [3];
   logic          last_o  [3];
   logic          req_o   [3];
   logic [1599:0] pso_o   [3];

   assign start_g[0] = start & (sel == 2'd0);
   assign start_g[1] = start & (sel == 2'd1);
   assign start_g[2] = start & (sel == 2'd2);
   assign ack_g[0]   = perm_ack & (sel == 2'd0);
   assign ack_g[1]   = perm_ack & (sel == 2'd1);
   assign ack_g[2]   = perm_ack & (sel == 2'd2);

   sha3_squeeze #(.RATE_LANES(17), .OUT_WORDS(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_g[0]), .state_in(state_in),
      .busy(busy_o[0]), .dout(dout_o[0]), .dout_valid(valid_o[0]),
      .dout_ready(dout_ready), .dout_last(last_o[0]), .perm_req(req_o[0]),
      .perm_state_out(pso_o[0]), .perm_ack(ack_g[0]), .perm_state_in(perm_state_in));

   sha3_squeeze #(.RATE_LANES(17), .OUT_WORDS(20)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_g[1]), .state_in(state_in),
      .busy(busy_o[1]), .dout(dout_o[1]), .dout_valid(valid_o[1]),
      .dout_ready(dout_ready), .dout_last(last_o[1]), .perm_req(req_o[1]),
      .perm_state_out(pso_o[1]), .perm_ack(ack_g[1]), .perm_state_in(perm_state_in));

   sha3_squeeze #(.RATE_LANES(1), .OUT_WORDS(3)) dut_c (
      .clk(clk), .rst_n(rst_n), .start(start_g[2]), .state_in(state_in),
      .busy(busy_o[2]), .dout(dout_o[2]), .dout_valid(valid_o[2]),
      .dout_ready(dout_ready), .dout_last(last_o[2]), .perm_req(req_o[2]),
      .perm_state_out(pso_o[2]), .perm_ack(ack_g[2]), .perm_state_in(perm_state_in));

   logic          busy, dout_valid, dout_last, perm_req;
   logic [63:0]   dout;
   logic [1599:0] perm_state_out;

   always_comb begin
      busy           = busy_o[sel];
      dout           = dout_o[sel];
      dout_valid     = valid_o[sel];
      dout_last      = last_o[sel];
      perm_req       = req_o[sel];
      perm_state_out = pso_o[sel];
   end

   int n_checks = 0;
   int n_pass   = 0;

   function automatic logic [63:0] lane(input logic [1599:0] s, input int i);
      return s[64*i +: 64];
   endfunction

   function automatic logic [1599:0] rand_state();
      logic [1599:0] s;
      for (int i = 0; i < 50; i++) s[32*i +: 32] = $urandom;
      return s;
   endfunction

   // --------------------------------------------------------------------------
   // One complete squeeze on the selected instance, entered and left at a
   // negedge with the instance idle. ready_mode: 0 always ready, 1 the
   // 1,0,0,1,0,1 pattern, 2 random. ack_delay = cycles perm_req stays high.
   // --------------------------------------------------------------------------
   task automatic run_squeeze(input int r, input int w, input int ack_delay,
                              input int ready_mode, input bit poke_start,
                              input bit stray_ack, input logic [1599:0] st0,
                              input bit fixed_perm, input logic [1599:0] fixed_val,
                              input bit stop_at_perm);
      logic [1599:0] states[$];
      logic [1599:0] nxt;
      logic [0:5]    pat_bits;
      logic [63:0]   exp_word;
      int            k = 0;
      int            perms = 0;
      int            req_cycles = 0;
      int            cycles = 1;
      int            pat = 0;
      bit            ack_given = 1'b0;
      bit            done = 1'b0;

      pat_bits = 6'b100101;
      states.push_back(st0);
      state_in   = st0;
      start      = 1'b1;
      dout_ready = 1'b0;
      perm_ack   = 1'b0;
      @(negedge clk);
      start    = 1'b0;
      state_in = rand_state();

      n_checks++;
      if ({busy, dout_valid} !== 2'b11)
         $display("FAIL start_latency: busy,valid got %b want 11", {busy, dout_valid});
      else n_pass++;

      while (!done) begin
         if (cycles > 2000) begin
            n_checks++;
            $display("FAIL timeout: words %0d of %0d after %0d cycles", k, w, cycles);
            start = 1'b0; perm_ack = 1'b0; dout_ready = 1'b0;
            return;
         end

         n_checks++;
         if ({busy, dout_valid | perm_req, dout_valid & perm_req} !== 3'b110)
            $display("FAIL in_flight: busy,valid,req got %b%b%b", busy, dout_valid, perm_req);
         else n_pass++;

         if (ack_given) begin
            n_checks++;
            if ({perm_req, dout_valid} !== 2'b01)
               $display("FAIL ack_latency: req,valid got %b want 01", {perm_req, dout_valid});
            else n_pass++;
            ack_given = 1'b0;
         end

         if (dout_valid) begin
            exp_word = lane(states[k / r], k % r);
            n_checks++;
            if (dout !== exp_word)
               $display("FAIL dout word %0d: got %h want %h", k, dout, exp_word);
            else n_pass++;
            n_checks++;
            if (dout_last !== (k == w - 1))
               $display("FAIL dout_last word %0d: got %b want %b", k, dout_last, k == w - 1);
            else n_pass++;
         end else if (perm_req) begin
            n_checks++;
            if (perm_state_out !== states[perms]) begin
               for (int i = 0; i < 25; i++)
                  if (lane(perm_state_out, i) !== lane(states[perms], i)) begin
                     $display("FAIL perm_state_out lane %0d: got %h want %h",
                              i, lane(perm_state_out, i), lane(states[perms], i));
                     break;
                  end
            end else n_pass++;
            if (stop_at_perm) begin
               start = 1'b0; perm_ack = 1'b0; dout_ready = 1'b0;
               return;
            end
         end

         // Drive inputs for the coming edge.
         start = poke_start && (perm_req || k == 1 || $urandom_range(0, 2) == 0);
         case (ready_mode)
            0:       dout_ready = 1'b1;
            1:       begin dout_ready = pat_bits[pat % 6]; pat++; end
            default: dout_ready = 1'($urandom_range(0, 1));
         endcase
         perm_ack = 1'b0;
         if (dout_valid && dout_ready) begin
            k++;
            if (k == w) begin
               done = 1'b1;
               if (poke_start) start = 1'b1;
            end
         end
         if (perm_req) begin
            req_cycles++;
            if (req_cycles == ack_delay) begin
               nxt = fixed_perm ? fixed_val : rand_state();
               states.push_back(nxt);
               perm_state_in = nxt;
               perm_ack      = 1'b1;
               perms++;
               req_cycles = 0;
               ack_given  = 1'b1;
            end else begin
               perm_state_in = rand_state();
            end
         end else if (stray_ack && dout_valid && $urandom_range(0, 1) == 1) begin
            perm_ack      = 1'b1;
            perm_state_in = rand_state();
         end
         @(negedge clk);
         cycles++;
      end

      start      = 1'b0;
      perm_ack   = 1'b0;
      dout_ready = 1'b0;
      n_checks++;
      if ({busy, dout_valid, perm_req} !== 3'b000)
         $display("FAIL end_idle: busy,valid,req got %b want 000", {busy, dout_valid, perm_req});
      else n_pass++;
      n_checks++;
      if (perms != (w - 1) / r)
         $display("FAIL perm_count: got %0d want %0d", perms, (w - 1) / r);
      else n_pass++;
      if (ready_mode == 0) begin
         n_checks++;
         if (cycles != w + 1 + perms * ack_delay)
            $display("FAIL total_cycles: got %0d want %0d", cycles, w + 1 + perms * ack_delay);
         else n_pass++;
      end
   endtask

   // --------------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         sel = 2'(i);
         #1;
         n_checks++;
         if ({busy, dout_valid, dout_last, perm_req} !== 4'b0000 || dout !== 64'd0 ||
             perm_state_out !== '0)
            $display("FAIL reset_state dut %0d: busy,valid,last,req %b dout %h",
                     i, {busy, dout_valid, dout_last, perm_req}, dout);
         else n_pass++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      sel   = 2'd0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [1599:0] s = '0;
      sel = 2'd0;
      for (int i = 0; i < 25; i++) s[64*i +: 64] = 64'h0101010101010101 * i;
      run_squeeze(17, 4, 1, 0, 1'b0, 1'b0, s, 1'b0, '0, 1'b0);
      run_squeeze(17, 4, 1, 0, 1'b0, 1'b0, rand_state(), 1'b0, '0, 1'b0);
   endtask

   task automatic test_backpressure();
      logic [1599:0] s = '0;
      sel = 2'd0;
      for (int i = 0; i < 25; i++) s[64*i +: 64] = 64'h0101010101010101 * i;
      run_squeeze(17, 4, 1, 1, 1'b0, 1'b0, s, 1'b0, '0, 1'b0);
      run_squeeze(17, 4, 1, 2, 1'b0, 1'b0, rand_state(), 1'b0, '0, 1'b0);
   endtask

   task automatic test_rate_boundary();
      logic [1599:0] p = '0;
      sel = 2'd1;
      for (int i = 0; i < 25; i++) p[64*i +: 64] = 64'hA5A5A5A5A5A5A500 + 64'(i);
      run_squeeze(17, 20, 5, 0, 1'b0, 1'b0, rand_state(), 1'b1, p, 1'b0);
      run_squeeze(17, 20, 1, 0, 1'b0, 1'b0, rand_state(), 1'b0, '0, 1'b0);
      run_squeeze(17, 20, 3, 2, 1'b0, 1'b0, rand_state(), 1'b0, '0, 1'b0);
   endtask

   task automatic test_start_while_busy();
      sel = 2'd1;
      run_squeeze(17, 20, 4, 2, 1'b1, 1'b0, rand_state(), 1'b0, '0, 1'b0);
      run_squeeze(17, 20, 2, 0, 1'b0, 1'b0, rand_state(), 1'b0, '0, 1'b0);
      sel = 2'd0;
      run_squeeze(17, 4, 1, 0, 1'b1, 1'b0, rand_state(), 1'b0, '0, 1'b0);
      run_squeeze(17, 4, 1, 0, 1'b0, 1'b0, rand_state(), 1'b0, '0, 1'b0);
   endtask

   task automatic test_reset_in_perm();
      sel = 2'd1;
      run_squeeze(17, 20, 5, 0, 1'b0, 1'b0, rand_state(), 1'b0, '0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, dout_valid, dout_last, perm_req} !== 4'b0000 || dout !== 64'd0 ||
          perm_state_out !== '0)
         $display("FAIL reset_in_perm: busy,valid,last,req %b dout %h",
                  {busy, dout_valid, dout_last, perm_req}, dout);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         perm_ack      = 1'b1;
         perm_state_in = rand_state();
         @(negedge clk);
         n_checks++;
         if ({busy, dout_valid, perm_req} !== 3'b000)
            $display("FAIL ack_after_reset %0d: busy,valid,req got %b want 000",
                     i, {busy, dout_valid, perm_req});
         else n_pass++;
      end
      perm_ack = 1'b0;
      run_squeeze(17, 20, 2, 2, 1'b0, 1'b0, rand_state(), 1'b0, '0, 1'b0);
   endtask

   task automatic test_rate_one();
      sel = 2'd2;
      for (int i = 0; i < 2; i++) begin
         perm_ack      = 1'b1;
         perm_state_in = rand_state();
         @(negedge clk);
         n_checks++;
         if ({busy, dout_valid, perm_req} !== 3'b000)
            $display("FAIL idle_stray_ack %0d: busy,valid,req got %b want 000",
                     i, {busy, dout_valid, perm_req});
         else n_pass++;
      end
      perm_ack = 1'b0;
      run_squeeze(1, 3, 2, 0, 1'b0, 1'b1, rand_state(), 1'b0, '0, 1'b0);
      run_squeeze(1, 3, 1, 2, 1'b0, 1'b1, rand_state(), 1'b0, '0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_rate_boundary();
      test_start_while_busy();
      test_reset_in_perm();
      test_rate_one();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
